// File: rtl/pipeline_ctrl_if.sv
// Hazard/sequencing bundle between the microRISC pipeline and pipeline_ctrl.
// master = controller side (drives stalls/flushes), slave = pipeline side.
interface pipeline_ctrl_if;
   logic [2:0]  id_rs;
   logic [2:0]  id_rt;
   logic        id_uses_rs;
   logic        id_uses_rt;
   logic        ex_mem_read;
   logic        ex_reg_write;
   logic [2:0]  ex_rd;
   logic        ex_redirect;
   logic        mem_req;
   logic        mem_ready;
   logic        pc_stall;
   logic        if_id_stall;
   logic        id_ex_stall;
   logic        ex_mem_stall;
   logic        if_id_flush;
   logic        id_ex_flush;
   logic        mem_wb_flush;
   logic        mem_timeout;
   logic [15:0] stall_cnt;
   logic [15:0] flush_cnt;
   logic [15:0] load_use_cnt;

   modport master (
      input  id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_reg_write,
             ex_rd, ex_redirect, mem_req, mem_ready,
      output pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
             if_id_flush, id_ex_flush, mem_wb_flush, mem_timeout,
             stall_cnt, flush_cnt, load_use_cnt
   );

   modport slave (
      output id_rs, id_rt, id_uses_rs, id_uses_rt, ex_mem_read, ex_reg_write,
             ex_rd, ex_redirect, mem_req, mem_ready,
      input  pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
             if_id_flush, id_ex_flush, mem_wb_flush, mem_timeout,
             stall_cnt, flush_cnt, load_use_cnt
   );
endinterface

// File: rtl/pipeline_ctrl.sv
// Stall/flush controller for the 5-stage microRISC pipeline.
// Define PIPE_CTRL_PERF_EN to build the stall/flush/load-use performance counters.
module pipeline_ctrl #(
   parameter int LOAD_BUBBLES = 1,
   parameter int MEM_TIMEOUT  = 15
) (
   input logic            clk,
   input logic            rst,
   pipeline_ctrl_if.master pif
);

   typedef enum logic {RUN, LOAD_WAIT} state_t;

   localparam logic       BCNT_LAST = 1'(LOAD_BUBBLES - 2);
   localparam logic [7:0] WCNT_HIT  = 8'(MEM_TIMEOUT - 1);

   state_t     state_q, state_d;
   logic       bcnt_q, bcnt_d;
   logic [7:0] wcnt_q, wcnt_d;
   logic       mem_timeout_q, mem_timeout_d;
   logic       mem_stall;
   logic       load_use;

   assign mem_stall = pif.mem_req & ~pif.mem_ready;
   assign load_use  = pif.ex_mem_read & pif.ex_reg_write & (pif.ex_rd != 3'd0) &
                      ((pif.id_uses_rs & (pif.id_rs == pif.ex_rd)) |
                       (pif.id_uses_rt & (pif.id_rt == pif.ex_rd)));

   always_comb begin
      state_d          = state_q;
      bcnt_d           = bcnt_q;
      pif.pc_stall     = 1'b0;
      pif.if_id_stall  = 1'b0;
      pif.id_ex_stall  = 1'b0;
      pif.ex_mem_stall = 1'b0;
      pif.if_id_flush  = 1'b0;
      pif.id_ex_flush  = 1'b0;
      pif.mem_wb_flush = 1'b0;
      if (rst) begin
         pif.if_id_flush  = 1'b1;
         pif.id_ex_flush  = 1'b1;
         pif.mem_wb_flush = 1'b1;
      end else if (mem_stall) begin
         // Freeze everything; state and bubble count resume untouched afterwards.
         pif.pc_stall     = 1'b1;
         pif.if_id_stall  = 1'b1;
         pif.id_ex_stall  = 1'b1;
         pif.ex_mem_stall = 1'b1;
         pif.mem_wb_flush = 1'b1;
      end else if (pif.ex_redirect) begin
         pif.if_id_flush = 1'b1;
         pif.id_ex_flush = 1'b1;
         state_d         = RUN;
         bcnt_d          = 1'b0;
      end else if (state_q == LOAD_WAIT) begin
         pif.pc_stall    = 1'b1;
         pif.if_id_stall = 1'b1;
         pif.id_ex_flush = 1'b1;
         bcnt_d          = bcnt_q + 1'b1;
         if (bcnt_q == BCNT_LAST) begin
            state_d = RUN;
         end
      end else if (load_use) begin
         pif.pc_stall    = 1'b1;
         pif.if_id_stall = 1'b1;
         pif.id_ex_flush = 1'b1;
         if (LOAD_BUBBLES == 2) begin
            state_d = LOAD_WAIT;
            bcnt_d  = 1'b0;
         end
      end
   end

   always_comb begin
      wcnt_d        = '0;
      mem_timeout_d = mem_timeout_q;
      if (mem_stall) begin
         wcnt_d = (wcnt_q == 8'hFF) ? wcnt_q : wcnt_q + 8'd1;
         if (wcnt_q == WCNT_HIT) begin
            mem_timeout_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= RUN;
         bcnt_q        <= 1'b0;
         wcnt_q        <= '0;
         mem_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         bcnt_q        <= bcnt_d;
         wcnt_q        <= wcnt_d;
         mem_timeout_q <= mem_timeout_d;
      end
   end

   assign pif.mem_timeout = mem_timeout_q;

`ifdef PIPE_CTRL_PERF_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic [15:0] flush_cnt_q, flush_cnt_d;
   logic [15:0] load_use_cnt_q, load_use_cnt_d;
   logic        lu_evt;
   logic        flush_evt;

   // A load-use hazard is counted only where it is first taken in RUN, not per bubble.
   assign lu_evt    = (state_q == RUN) & ~mem_stall & ~pif.ex_redirect & load_use;
   assign flush_evt = ~mem_stall & pif.ex_redirect;

   always_comb begin
      stall_cnt_d    = stall_cnt_q;
      flush_cnt_d    = flush_cnt_q;
      load_use_cnt_d = load_use_cnt_q;
      if (pif.pc_stall && stall_cnt_q != 16'hFFFF) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
      if (flush_evt && flush_cnt_q != 16'hFFFF) begin
         flush_cnt_d = flush_cnt_q + 16'd1;
      end
      if (lu_evt && load_use_cnt_q != 16'hFFFF) begin
         load_use_cnt_d = load_use_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q    <= '0;
         flush_cnt_q    <= '0;
         load_use_cnt_q <= '0;
      end else begin
         stall_cnt_q    <= stall_cnt_d;
         flush_cnt_q    <= flush_cnt_d;
         load_use_cnt_q <= load_use_cnt_d;
      end
   end

   assign pif.stall_cnt    = stall_cnt_q;
   assign pif.flush_cnt    = flush_cnt_q;
   assign pif.load_use_cnt = load_use_cnt_q;
`else
   assign pif.stall_cnt    = '0;
   assign pif.flush_cnt    = '0;
   assign pif.load_use_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: single-cycle vector table on a
// LOAD_BUBBLES=1 instance plus multi-cycle sequences on a LOAD_BUBBLES=2 instance.
module tb_pipeline_ctrl;

   typedef struct packed {
      logic [2:0] id_rs;
      logic [2:0] id_rt;
      logic       uses_rs;
      logic       uses_rt;
      logic       mem_read;
      logic       reg_write;
      logic [2:0] ex_rd;
      logic       redirect;
      logic       mem_req;
      logic       mem_ready;
   } in_t;

   // {pc, if_id_s, id_ex_s, ex_mem_s, if_id_f, id_ex_f, mem_wb_f}
   typedef logic [6:0] ctl_t;

   typedef struct {
      in_t  in;
      ctl_t exp;
   } vec_t;

   localparam ctl_t C_IDLE = 7'b0000_000;
   localparam ctl_t C_LU   = 7'b1100_010;
   localparam ctl_t C_RD   = 7'b0000_110;
   localparam ctl_t C_MEM  = 7'b1111_001;
   localparam ctl_t C_RST  = 7'b0000_111;

   logic clk = 1'b0;
   logic rst = 1'b1;
   in_t  in1, in2;
   ctl_t act1, act2;
   ctl_t exp_q[$];
   int   nvec  = 0;
   int   nfail = 0;

   always #5 clk = ~clk;

   pipeline_ctrl_if if1 ();
   pipeline_ctrl_if if2 ();

   assign {if1.id_rs, if1.id_rt, if1.id_uses_rs, if1.id_uses_rt, if1.ex_mem_read,
           if1.ex_reg_write, if1.ex_rd, if1.ex_redirect, if1.mem_req, if1.mem_ready} = in1;
   assign {if2.id_rs, if2.id_rt, if2.id_uses_rs, if2.id_uses_rt, if2.ex_mem_read,
           if2.ex_reg_write, if2.ex_rd, if2.ex_redirect, if2.mem_req, if2.mem_ready} = in2;
   assign act1 = {if1.pc_stall, if1.if_id_stall, if1.id_ex_stall, if1.ex_mem_stall,
                  if1.if_id_flush, if1.id_ex_flush, if1.mem_wb_flush};
   assign act2 = {if2.pc_stall, if2.if_id_stall, if2.id_ex_stall, if2.ex_mem_stall,
                  if2.if_id_flush, if2.id_ex_flush, if2.mem_wb_flush};

   pipeline_ctrl #(.LOAD_BUBBLES(1), .MEM_TIMEOUT(15)) dut1 (.clk(clk), .rst(rst), .pif(if1.master));
   pipeline_ctrl #(.LOAD_BUBBLES(2), .MEM_TIMEOUT(15)) dut2 (.clk(clk), .rst(rst), .pif(if2.master));

   function automatic in_t mk(input logic [2:0] rs, input logic [2:0] rt, input logic urs,
                              input logic urt, input logic mr, input logic rw,
                              input logic [2:0] rd, input logic redir,
                              input logic mreq, input logic mrdy);
      in_t v;
      v = '{id_rs: rs, id_rt: rt, uses_rs: urs, uses_rt: urt, mem_read: mr,
            reg_write: rw, ex_rd: rd, redirect: redir, mem_req: mreq, mem_ready: mrdy};
      return v;
   endfunction

   function automatic logic [15:0] cnt_exp(input int v);
`ifdef PIPE_CTRL_PERF_EN
      return 16'(v);
`else
      return 16'(v - v);
`endif
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      nvec++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one cycle on the selected instance; the other idles.
   task automatic step(input int sel, input in_t v, input ctl_t exp, input string name);
      ctl_t e;
      @(posedge clk);
      #1;
      in1 = '0;
      in2 = '0;
      if (sel == 1) in1 = v;
      else          in2 = v;
      exp_q.push_back(exp);
      @(negedge clk);
      e = exp_q.pop_front();
      chk(name, 16'(sel == 1 ? act1 : act2), 16'(e));
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      in1 = '0;
      in2 = '0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   vec_t tbl[13];
   in_t  lu, idle, redir, mstall;

   initial begin
      idle   = '0;
      lu     = mk(3'd3, 3'd0, 1, 0, 1, 1, 3'd3, 0, 0, 0);
      redir  = mk(3'd0, 3'd0, 0, 0, 0, 0, 3'd0, 1, 0, 0);
      mstall = mk(3'd0, 3'd0, 0, 0, 0, 0, 3'd0, 0, 1, 0);

      tbl[0]  = '{idle, C_IDLE};
      tbl[1]  = '{lu, C_LU};
      tbl[2]  = '{mk(3'd0, 3'd0, 1, 1, 1, 1, 3'd0, 0, 0, 0), C_IDLE};  // r0 never hazards
      tbl[3]  = '{mk(3'd1, 3'd5, 0, 1, 1, 1, 3'd5, 0, 0, 0), C_LU};    // rt match
      tbl[4]  = '{mk(3'd1, 3'd5, 0, 0, 1, 1, 3'd5, 0, 0, 0), C_IDLE};  // rt not used
      tbl[5]  = '{mk(3'd3, 3'd0, 1, 0, 1, 0, 3'd3, 0, 0, 0), C_IDLE};  // no reg write
      tbl[6]  = '{mk(3'd3, 3'd0, 1, 0, 0, 1, 3'd3, 0, 0, 0), C_IDLE};  // not a load
      tbl[7]  = '{redir, C_RD};
      tbl[8]  = '{mk(3'd3, 3'd0, 1, 0, 1, 1, 3'd3, 1, 0, 0), C_RD};    // redirect beats load-use
      tbl[9]  = '{mstall, C_MEM};
      tbl[10] = '{mk(3'd3, 3'd0, 1, 0, 1, 1, 3'd3, 1, 1, 0), C_MEM};   // mem stall beats all
      tbl[11] = '{mk(3'd0, 3'd0, 0, 0, 0, 0, 3'd0, 0, 1, 1), C_IDLE};  // mem ready
      tbl[12] = '{mk(3'd2, 3'd0, 1, 0, 1, 1, 3'd3, 0, 0, 0), C_IDLE};  // rs mismatch

      in1 = '0;
      in2 = '0;
      #2;
      chk("reset_ctl", 16'(act1), 16'(C_RST));
      chk("reset_timeout", 16'(if1.mem_timeout), 16'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("idle_after_reset", 16'(act2), 16'(C_IDLE));
      chk("timeout_after_reset", 16'(if2.mem_timeout), 16'd0);
      chk("stall_cnt_after_reset", if2.stall_cnt, 16'd0);
      chk("flush_cnt_after_reset", if2.flush_cnt, 16'd0);
      chk("lu_cnt_after_reset", if2.load_use_cnt, 16'd0);

      // Vector table on LOAD_BUBBLES=1 instance
      do_reset();
      begin
         int n_st, n_fl, n_lu;
         n_st = 0; n_fl = 0; n_lu = 0;
         for (int i = 0; i < 13; i++) begin
            step(1, tbl[i].in, tbl[i].exp, $sformatf("vec%0d", i));
            if (tbl[i].exp[6]) n_st++;
            if (tbl[i].exp == C_RD) n_fl++;
            if (tbl[i].exp == C_LU) n_lu++;
         end
         step(1, idle, C_IDLE, "vec_tail_idle");
         chk("tbl_stall_cnt", if1.stall_cnt, cnt_exp(n_st));
         chk("tbl_flush_cnt", if1.flush_cnt, cnt_exp(n_fl));
         chk("tbl_lu_cnt", if1.load_use_cnt, cnt_exp(n_lu));
         chk("tbl_timeout", 16'(if1.mem_timeout), 16'd0);
      end

      // LOAD_BUBBLES=2: two bubbles, then free
      do_reset();
      step(2, lu, C_LU, "lb2_bubble1");
      step(2, idle, C_LU, "lb2_bubble2");
      step(2, idle, C_IDLE, "lb2_done");
      chk("lb2_stall_cnt", if2.stall_cnt, cnt_exp(2));
      chk("lb2_lu_cnt", if2.load_use_cnt, cnt_exp(1));

      // Redirect with load-use together: stays in RUN, no load-use counted
      do_reset();
      step(2, tbl[8].in, C_RD, "redir_lu_flush");
      step(2, idle, C_IDLE, "redir_lu_stays_run");
      chk("redir_lu_lu_cnt", if2.load_use_cnt, cnt_exp(0));
      chk("redir_lu_flush_cnt", if2.flush_cnt, cnt_exp(1));
      chk("redir_lu_stall_cnt", if2.stall_cnt, cnt_exp(0));

      // Memory wait arriving mid-LOAD_WAIT; the bubble resumes afterwards
      do_reset();
      step(2, lu, C_LU, "mw_bubble1");
      for (int i = 0; i < 3; i++) step(2, mstall, C_MEM, $sformatf("mw_wait%0d", i));
      step(2, idle, C_LU, "mw_bubble2");
      step(2, idle, C_IDLE, "mw_done");
      chk("mw_stall_cnt", if2.stall_cnt, cnt_exp(5));
      chk("mw_lu_cnt", if2.load_use_cnt, cnt_exp(1));

      // Redirect during LOAD_WAIT wins and returns to RUN
      do_reset();
      step(2, lu, C_LU, "lwr_bubble1");
      step(2, redir, C_RD, "lwr_redirect");
      step(2, idle, C_IDLE, "lwr_run");

      // Timeout: 15 wait cycles set the sticky flag on the 15th edge
      do_reset();
      for (int i = 1; i <= 15; i++) begin
         step(2, mstall, C_MEM, $sformatf("to_wait%0d", i));
         if (i >= 14) chk($sformatf("to_pre%0d", i), 16'(if2.mem_timeout), 16'd0);
      end
      step(2, idle, C_IDLE, "to_release");
      chk("to_set", 16'(if2.mem_timeout), 16'd1);
      step(2, idle, C_IDLE, "to_idle");
      chk("to_sticky", 16'(if2.mem_timeout), 16'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("to_async_clear", 16'(if2.mem_timeout), 16'd0);
      chk("async_rst_ctl", 16'(act2), 16'(C_RST));
      @(posedge clk);
      #1;
      rst = 1'b0;

      // 14 waits are one short of the limit
      do_reset();
      for (int i = 0; i < 14; i++) step(2, mstall, C_MEM, "short_wait");
      step(2, idle, C_IDLE, "short_release");
      chk("short_no_timeout", 16'(if2.mem_timeout), 16'd0);

      if (exp_q.size() != 0) begin
         nvec++;
         nfail++;
         $display("FAIL scoreboard_drain: got %0d left expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Hazard and sequencing controller for the 5-stage microRISC pipeline (IF/ID/EX/MEM/WB). It drives the pipeline stall and flush inputs of each stage:
- `if_id_stall`/`if_id_flush` feed the decode stage's `stall`/`flush`.
- It inserts load-use bubbles, squashes wrong-path instructions on branch/jump redirects, and freezes the pipe while the data memory is not ready.
- Optional performance counters report stall and flush activity.

## Interface
- `LOAD_BUBBLES`, default 1: bubbles inserted per load-use hazard. Legal values 1 or 2; use 2 when there is no MEM→EX forwarding.
- `MEM_TIMEOUT`, default 15: consecutive memory-wait cycles that set `mem_timeout`. Range 1..255.
- `clk` input 1: single clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `id_rs`, `id_rt` input 3 each: source registers of the instruction in ID.
- `id_uses_rs`, `id_uses_rt` input 1 each: ID instruction actually reads rs/rt.
- `ex_mem_read` input 1: instruction in EX is a load.
- `ex_reg_write` input 1: EX instruction writes a register.
- `ex_rd` input 3: EX destination register.
- `ex_redirect` input 1: EX resolved a taken branch, jump or jump_reg.
- `mem_req` input 1: MEM stage is accessing data memory.
- `mem_ready` input 1: data memory completes this cycle.
- `pc_stall`, `if_id_stall`, `id_ex_stall`, `ex_mem_stall` output 1 each: hold the PC / pipeline register.
- `if_id_flush`, `id_ex_flush`, `mem_wb_flush` output 1 each: load a bubble into that pipeline register.
- `mem_timeout` output 1: sticky flag, memory wait exceeded `MEM_TIMEOUT`.
- `stall_cnt`, `flush_cnt`, `load_use_cnt` output 16 each: performance counters.

## Operation
- `mem_stall = mem_req & ~mem_ready`. This condition has the highest priority in every state.
  - All four stalls = 1, `mem_wb_flush` = 1, all other flushes = 0.
  - FSM state and bubble counter hold their values.
- `load_use = ex_mem_read & ex_reg_write & (ex_rd != 0) & ((id_uses_rs & id_rs == ex_rd) | (id_uses_rt & id_rt == ex_rd))`.
- FSM states are RUN and LOAD_WAIT. A 1-bit bubble counter `bcnt` is used in LOAD_WAIT.
- **RUN**, with no `mem_stall`:
  - If `ex_redirect`: `if_id_flush` = `id_ex_flush` = 1, no stalls. Stay in RUN.
  - Else if `load_use`: `pc_stall` = `if_id_stall` = 1, `id_ex_flush` = 1.
    - If `LOAD_BUBBLES` = 2, go to LOAD_WAIT with `bcnt` = 0.
    - Otherwise stay in RUN.
  - Else all outputs are 0.
- **LOAD_WAIT**, with no `mem_stall`:
  - `pc_stall` = `if_id_stall` = 1, `id_ex_flush` = 1. Return to RUN next cycle.
  - An `ex_redirect` in this state takes priority: apply the redirect flush and return to RUN.
- `ex_redirect` always outranks `load_use`, because the ID instruction is on the wrong path.
- Register r0 never creates a hazard.
- Timeout: 8-bit `wcnt` increments on each `mem_stall` cycle and clears when `mem_stall` = 0.
  - `mem_timeout` is set on the cycle `wcnt` == `MEM_TIMEOUT-1` while `mem_stall` is still asserted.
  - It stays set until `rst`. `wcnt` saturates.
- While `rst` = 1:
  - All stalls = 0, `if_id_flush` = `id_ex_flush` = `mem_wb_flush` = 1.
  - State = RUN, `bcnt` = 0, `wcnt` = 0, `mem_timeout` = 0, counters = 0.

## Timing
- Stall and flush outputs are combinational from the current state and inputs, and take effect on the same edge the hazard is seen. Zero cycles of latency.
- FSM, counters and `mem_timeout` update on the rising edge of `clk`. Reset is asynchronous: an assertion mid-operation forces RUN immediately.
- Load-use costs `LOAD_BUBBLES` cycles. A redirect costs 2 squashed slots.
- A `mem_stall` lasting N cycles adds exactly N cycles. Any hazard pending underneath it resumes unchanged after `mem_ready`.
- No combinational path from any output back to any input.

## Configuration
- `PIPE_CTRL_PERF_EN` defined:
  - `stall_cnt` increments on each cycle `pc_stall` = 1.
  - `flush_cnt` increments on each `ex_redirect` honored, i.e. outside `mem_stall`.
  - `load_use_cnt` increments once per load-use hazard, not per bubble.
  - All three saturate at 16'hFFFF.
- Not defined: counters are not implemented and the three outputs are tied to 16'h0000.

## Test plan
- Reset release → all stalls 0 and flushes 0 in the first idle cycle; `mem_timeout` = 0; counters = 0.
- Load-use: `ex_mem_read` = 1, `ex_rd` = 3, `id_rs` = 3, `id_uses_rs` = 1, `LOAD_BUBBLES` = 1 → exactly one cycle of `pc_stall` = `if_id_stall` = `id_ex_flush` = 1. With `ex_rd` = 0 there is no stall. With `LOAD_BUBBLES` = 2 there are two cycles.
- `ex_redirect` and `load_use` in the same cycle → `if_id_flush` = `id_ex_flush` = 1, `pc_stall` = 0, state stays RUN, `load_use_cnt` unchanged.
- `mem_req` = 1, `mem_ready` = 0 for 3 cycles, arriving mid-LOAD_WAIT → all stalls and `mem_wb_flush` = 1 for 3 cycles. The LOAD_WAIT bubble then completes; `stall_cnt` = 5 (3 memory-wait cycles + 2 load-use bubble cycles), assuming `LOAD_BUBBLES` = 2, the hazard first seen in RUN and the memory wait starting in the following LOAD_WAIT cycle.
- `mem_ready` held 0 for 15 cycles with `MEM_TIMEOUT` = 15 → `mem_timeout` rises after the 15th cycle and stays 1 after `mem_ready`. `rst` clears it asynchronously.
- Build without `PIPE_CTRL_PERF_EN`, rerun the load-use scenario → the three counters read 16'h0000 and the stall/flush behaviour is identical.
